keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
Responder side of the 4x4 matrix-keypad scan interface: it behaves like a physical keypad wired between the scanner's row drives and column senses. Key codes are queued through a valid/ready handshake. Each key is "pressed" for a programmable time, then "released" for a programmable gap. Used for scripted/self-test entry into the calculator and as the bench model for the keypad scanner.

Parameters:
HOLD_CYCLES, 2_000_000, clocks a key stays closed (40 ms at 50 MHz); must be >= 1
GAP_CYCLES, 2_000_000, clocks of all-open time after each key before the next; must be >= 1
FIFO_DEPTH, 4, pending key codes buffered (power of two)
BOUNCE_PERIOD, 50_000, clocks per bounce toggle (used only with the optional feature)

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
rst  in  1  asynchronous, active-high reset
key_valid  in  1  key code offered
key_code  in  4  [3:2] = row index, [1:0] = column index
key_ready  out  1  FIFO not full; transfer occurs when key_valid && key_ready at the clk edge
rows  in  4  scanner row drives, active-low; one row is low at a time in normal operation
cols  out  4  column senses to the scanner, active-low (1 = open contact)
busy  out  1  high in PRESS or GAP, or while the FIFO is non-empty
pressed  out  1  contact currently closed (state PRESS, after bounce if enabled)
done  out  1  one-cycle pulse on the clock where GAP finishes

Behaviour:
- Reset (async, while rst=1): FIFO emptied, state IDLE, counter 0, done=0, pressed=0, busy=0, cols=4'hF, key_ready=1.
- key_ready = !fifo_full, taken from registers; no combinational path from key_valid.
- A push and a pop in the same cycle are both performed. The FIFO never overflows or underflows. Codes leave in arrival order.
- FSM states:
  - IDLE: if FIFO non-empty, pop into cur_row/cur_col, load counter = HOLD_CYCLES-1, go to PRESS.
  - PRESS: decrement the counter; at 0 load counter = GAP_CYCLES-1 and go to GAP.
  - GAP: decrement the counter; at 0 pulse done and go to IDLE.
- Latency: a code accepted at edge N is in the FIFO at N+1, and PRESS is entered at edge N+2. A key therefore occupies exactly HOLD_CYCLES clocks in PRESS and GAP_CYCLES clocks in GAP. Back-to-back keys add one IDLE cycle between them.
- cols is combinational from rows and registered state:
  - cols[c] = 0 iff pressed && c == cur_col && rows[cur_row] == 0; every other column bit is 1.
  - Other rows being low does not affect the result, so an all-low rows input yields a single low column.
  - No added latency relative to the row drive, matching a real switch.
- busy = (state != IDLE) || !fifo_empty.
- Reset mid-PRESS or mid-GAP: cols goes to 4'hF immediately (async); the pending and current key are discarded; no done pulse.
- key_valid while key_ready=0: no transfer; the source must hold the code.

Optional Feature:
KEYPAD_EMU_BOUNCE_EN
- Defined:
  - The first 6*BOUNCE_PERIOD clocks of PRESS toggle the contact every BOUNCE_PERIOD clocks, starting open: open, closed, open, closed, open, closed.
  - The first 6*BOUNCE_PERIOD clocks of GAP likewise toggle, starting closed.
  - pressed follows the bouncing contact.
  - HOLD_CYCLES and GAP_CYCLES must both be > 6*BOUNCE_PERIOD.
- Undefined: clean contact; pressed = (state == PRESS); the BOUNCE_PERIOD parameter is ignored.

Decomposition:
- Package keypad_emu_pkg:
  - state enum {IDLE, PRESS, GAP}
  - key_code_t (4-bit)
  - functions code_row() and code_col()
  - constant BOUNCE_TOGGLES = 6
- Sub-module keypad_emu_fifo: synchronous FIFO (clk, rst async, push/pop, full/empty, data out) parameterised by width and depth.

Test Plan:
All scenarios use HOLD_CYCLES=8, GAP_CYCLES=4, FIFO_DEPTH=4 unless stated.
1. Reset: assert rst with rows=4'b1110 -> cols=4'hF, key_ready=1, busy=0, done=0, pressed=0.
2. Single key: push code 4'h6 at edge N, hold rows=4'b1101 -> cols=4'b1011 for edges N+2..N+9. rows=4'b1110 in the same window -> cols=4'hF. done pulses at edge N+13.
3. Ordering/backpressure: keep key_valid high presenting codes 1,2,3,4,5,6,7 -> key_ready drops once 4 codes are pending; keys emerge on cols in order 1..7 with no loss or duplication.
4. Rows all low (4'b0000) during PRESS of code 4'hF -> cols=4'b0111 only.
5. Reset mid-PRESS of code 4'h0 at its 3rd cycle -> cols=4'hF in the same cycle; the queued code 4'h1 is never emitted; no done pulse.
6. Bounce: with KEYPAD_EMU_BOUNCE_EN, BOUNCE_PERIOD=2, HOLD=20, GAP=20, code 4'h0, rows=4'b1110 -> cols[0] pattern 1,1,0,0,1,1,0,0,1,1,0,0 then steady 0. GAP mirrors it with 0,0,1,1... then steady 1.

Source files
------------

// File: rtl/keypad_emu_pkg.sv
// Shared types and helpers for the keypad emulator.
package keypad_emu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_e;

  typedef logic [3:0] key_code_t;

  // Number of contact toggles at the start of PRESS and of GAP when bouncing
  localparam int BOUNCE_TOGGLES = 6;

  function automatic logic [1:0] code_row(input key_code_t code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] code_col(input key_code_t code);
    return code[1:0];
  endfunction

  // Contact level (1 = closed) for a bounce phase; phases at or beyond
  // BOUNCE_TOGGLES are the settled level, the opposite of the starting level.
  function automatic logic bounce_level(input logic [2:0] phase, input logic start_closed);
    logic lvl;
    if (phase >= 3'(BOUNCE_TOGGLES)) begin
      lvl = !start_closed;
    end else begin
      lvl = start_closed ^ phase[0];
    end
    return lvl;
  endfunction

endpackage

// File: rtl/keypad_emu_fifo.sv
// Small synchronous FIFO holding pending key codes. Push is ignored when full
// and pop is ignored when empty, so it can neither overflow nor underflow.
module keypad_emu_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_s;
  logic             pop_s;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    logic [AW-1:0] n;
    if (p == AW'(DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + AW'(1);
    end
    return n;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; a push and a pop may happen together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// Responder side of a 4x4 matrix keypad: queued key codes are "pressed" for
// HOLD_CYCLES clocks, then released for GAP_CYCLES clocks.
// Optional contact bounce is enabled by defining KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator
  import keypad_emu_pkg::*;
#(
  parameter int HOLD_CYCLES   = 2_000_000,
  parameter int GAP_CYCLES    = 2_000_000,
  parameter int FIFO_DEPTH    = 4,
  parameter int BOUNCE_PERIOD = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       busy,
  output logic       pressed,
  output logic       done
);

  localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD  = 32'(GAP_CYCLES - 1);

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_PERIOD < 1) begin : g_bad_param
    $error("keypad_emulator: HOLD_CYCLES, GAP_CYCLES and BOUNCE_PERIOD must be >= 1");
  end

  state_e    state_q;
  logic [31:0] cnt_q;
  logic [1:0]  cur_row_q;
  logic [1:0]  cur_col_q;
  logic        done_q;
  logic        pressed_q;
  logic [3:0]  cols_s;

  key_code_t   fifo_data_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        fifo_pop_s;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [31:0] BP_LAST = 32'(BOUNCE_PERIOD - 1);

  if (HOLD_CYCLES <= BOUNCE_TOGGLES * BOUNCE_PERIOD ||
      GAP_CYCLES  <= BOUNCE_TOGGLES * BOUNCE_PERIOD) begin : g_bad_bounce
    $error("keypad_emulator: HOLD_CYCLES and GAP_CYCLES must exceed the bounce interval");
  end

  logic [31:0] bcnt_q;
  logic [2:0]  bphase_q;
`endif

  assign fifo_pop_s = (state_q == IDLE) && !fifo_empty_s;

  keypad_emu_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (key_valid),
    .data_i  (key_code),
    .pop_i   (fifo_pop_s),
    .data_o  (fifo_data_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Key sequencer: pop a code, hold the contact, release it, then pulse done.
  // done is raised during the final GAP cycle so it is high on the edge that
  // ends GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_row_q <= '0;
      cur_col_q <= '0;
      done_q    <= 1'b0;
      pressed_q <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      bcnt_q    <= '0;
      bphase_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty_s) begin
            state_q   <= PRESS;
            cnt_q     <= HOLD_LOAD;
            cur_row_q <= code_row(fifo_data_s);
            cur_col_q <= code_col(fifo_data_s);
`ifdef KEYPAD_EMU_BOUNCE_EN
            bcnt_q    <= '0;
            bphase_q  <= '0;
            pressed_q <= bounce_level(3'd0, 1'b0);
`else
            pressed_q <= 1'b1;
`endif
          end
        end
        PRESS: begin
          if (cnt_q == 32'd0) begin
            state_q <= GAP;
            cnt_q   <= GAP_LOAD;
            done_q  <= (GAP_LOAD == 32'd0);
`ifdef KEYPAD_EMU_BOUNCE_EN
            bcnt_q    <= '0;
            bphase_q  <= '0;
            pressed_q <= bounce_level(3'd0, 1'b1);
`else
            pressed_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q - 32'd1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            if (bphase_q < 3'(BOUNCE_TOGGLES)) begin
              if (bcnt_q == BP_LAST) begin
                bcnt_q    <= '0;
                bphase_q  <= bphase_q + 3'd1;
                pressed_q <= bounce_level(bphase_q + 3'd1, 1'b0);
              end else begin
                bcnt_q <= bcnt_q + 32'd1;
              end
            end
`endif
          end
        end
        GAP: begin
          if (cnt_q == 32'd0) begin
            state_q   <= IDLE;
            pressed_q <= 1'b0;
          end else begin
            cnt_q  <= cnt_q - 32'd1;
            done_q <= (cnt_q == 32'd1);
`ifdef KEYPAD_EMU_BOUNCE_EN
            if (bphase_q < 3'(BOUNCE_TOGGLES)) begin
              if (bcnt_q == BP_LAST) begin
                bcnt_q    <= '0;
                bphase_q  <= bphase_q + 3'd1;
                pressed_q <= bounce_level(bphase_q + 3'd1, 1'b1);
              end else begin
                bcnt_q <= bcnt_q + 32'd1;
              end
            end
`endif
          end
        end
        default: begin
          state_q   <= IDLE;
          pressed_q <= 1'b0;
        end
      endcase
    end
  end

  // Switch model: the closed contact connects the current row to its column.
  always_comb begin
    cols_s = 4'hF;
    if (pressed_q && !rows[cur_row_q]) begin
      cols_s[cur_col_q] = 1'b0;
    end else begin
      cols_s = 4'hF;
    end
  end

  assign cols      = cols_s;
  assign key_ready = !fifo_full_s;
  assign busy      = (state_q != IDLE) || !fifo_empty_s;
  assign pressed   = pressed_q;
  assign done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: directed scenarios plus random
// traffic, all compared against a cycle-level reference model of key timing.
module tb_keypad_emulator;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int HOLD_C = 20;
  localparam int GAP_C  = 20;
`else
  localparam int HOLD_C = 8;
  localparam int GAP_C  = 4;
`endif
  localparam int BP_C    = 2;
  localparam int DEPTH_C = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       busy;
  logic       pressed;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending codes, and the age of the current key in clocks
  logic [3:0] mq[$];
  bit         m_active = 1'b0;
  int         m_t      = 0;
  logic [3:0] m_cur    = 4'h0;
  bit         last_accept;
  int         step_no  = 0;
  int         done_seen_step;
  int         done_count;
  bit         saw_not_ready;

  keypad_emulator #(
    .HOLD_CYCLES   (HOLD_C),
    .GAP_CYCLES    (GAP_C),
    .FIFO_DEPTH    (DEPTH_C),
    .BOUNCE_PERIOD (BP_C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .rows      (rows),
    .cols      (cols),
    .busy      (busy),
    .pressed   (pressed),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Contact closed at key age t (PRESS spans ages 0..HOLD_C-1, GAP follows)
  function automatic bit m_closed(input int t);
    if (t < HOLD_C) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
      if (t < 6 * BP_C) return ((t / BP_C) % 2) == 1;
`endif
      return 1'b1;
    end
`ifdef KEYPAD_EMU_BOUNCE_EN
    if (t - HOLD_C < 6 * BP_C) return (((t - HOLD_C) / BP_C) % 2) == 0;
`endif
    return 1'b0;
  endfunction

  task automatic check_outputs();
    logic       e_pressed;
    logic [3:0] e_cols;
    logic       e_busy;
    logic       e_done;
    logic       e_ready;
    e_cols = 4'hF;
    if (rst) begin
      e_pressed = 1'b0;
      e_busy    = 1'b0;
      e_done    = 1'b0;
      e_ready   = 1'b1;
    end else begin
      e_pressed = m_active && m_closed(m_t);
      e_busy    = m_active || (mq.size() != 0);
      e_done    = m_active && (m_t == HOLD_C + GAP_C - 1);
      e_ready   = (mq.size() < DEPTH_C);
      if (e_pressed && rows[m_cur[3:2]] == 1'b0) e_cols[m_cur[1:0]] = 1'b0;
    end
    check("cols", cols, e_cols);
    check("pressed", {3'b000, pressed}, {3'b000, e_pressed});
    check("busy", {3'b000, busy}, {3'b000, e_busy});
    check("done", {3'b000, done}, {3'b000, e_done});
    check("key_ready", {3'b000, key_ready}, {3'b000, e_ready});
    if (done === 1'b1) begin
      done_seen_step = step_no;
      done_count++;
    end
    if (key_ready === 1'b0) saw_not_ready = 1'b1;
  endtask

  // Advance the model by one clock edge using the inputs held across it
  task automatic model_edge(input logic v, input logic [3:0] c);
    bit do_pop;
    bit do_push;
    if (rst) begin
      mq.delete();
      m_active    = 1'b0;
      m_t         = 0;
      last_accept = 1'b0;
    end else begin
      do_pop      = !m_active && (mq.size() != 0);
      do_push     = v && (mq.size() < DEPTH_C);
      last_accept = do_push;
      if (m_active) begin
        m_t++;
        if (m_t == HOLD_C + GAP_C) m_active = 1'b0;
      end else if (do_pop) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end
      if (do_push) mq.push_back(c);
    end
  endtask

  // One clock: drive at the falling edge, check, then take the rising edge
  task automatic step(input logic v, input logic [3:0] c, input logic [3:0] r);
    key_valid = v;
    key_code  = c;
    rows      = r;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge(v, c);
    step_no++;
    @(negedge clk);
  endtask

  function automatic logic [3:0] rand_rows();
    logic [3:0] r;
    case ($urandom_range(0, 5))
      0: r = 4'b1110;
      1: r = 4'b1101;
      2: r = 4'b1011;
      3: r = 4'b0111;
      4: r = 4'b0000;
      default: r = 4'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    int push_step;
    int idx;
    int guard;
    logic [3:0] code_r;

    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    rows      = 4'b1110;
    @(negedge clk);

    // 1. Reset state
    step(1'b0, 4'h0, 4'b1110);
    step(1'b0, 4'h0, 4'b1110);
    rst = 1'b0;

    // 2. Single key 6: row 1, column 2; done on edge N+13
    done_seen_step = -1;
    push_step = step_no;
    step(1'b1, 4'h6, 4'b1101);
    for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 4'b1101);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 4'b1110);
    step(1'b0, 4'h0, 4'b1101);
    for (int i = 0; i < HOLD_C + GAP_C + 4; i++) step(1'b0, 4'h0, 4'b1101);
    check("done_latency", 4'(done_seen_step - push_step), 4'(HOLD_C + GAP_C + 1));

    // 3. Ordering and backpressure with codes 1..7
    saw_not_ready = 1'b0;
    done_count    = 0;
    idx           = 1;
    guard         = 0;
    while (idx <= 7 && guard < 400) begin
      step(1'b1, 4'(idx), rand_rows());
      if (last_accept) idx++;
      guard++;
    end
    check("all_codes_accepted", 4'(idx), 4'd8);
    check("ready_dropped", {3'b000, saw_not_ready}, 4'd1);
    for (int i = 0; i < 8 * (HOLD_C + GAP_C + 1); i++) step(1'b0, 4'h0, rand_rows());
    check("done_count", 4'(done_count), 4'd7);

    // 4. All rows low during key F: only column 3 low
    step(1'b1, 4'hF, 4'b0000);
    step(1'b0, 4'h0, 4'b0000);
    step(1'b0, 4'h0, 4'b0000);
    check("all_rows_low", cols, 4'b0111);
    for (int i = 0; i < HOLD_C + GAP_C + 2; i++) step(1'b0, 4'h0, 4'b0000);

    // 5. Reset during the third PRESS cycle of key 0, key 1 queued behind it
    step(1'b1, 4'h0, 4'b1110);
    step(1'b1, 4'h1, 4'b1110);
    step(1'b0, 4'h0, 4'b1110);
    step(1'b0, 4'h0, 4'b1110);
    rows = 4'b1110;
    #1;
    check_outputs();
    check("pre_reset_cols", cols, 4'b1110);
    rst = 1'b1;
    #1;
    check("reset_cols_async", cols, 4'hF);
    check_outputs();
    @(posedge clk);
    model_edge(1'b0, 4'h0);
    step_no++;
    @(negedge clk);
    step(1'b0, 4'h0, 4'b1110);
    rst        = 1'b0;
    done_count = 0;
    for (int i = 0; i < HOLD_C + GAP_C + 4; i++) step(1'b0, 4'h0, 4'b1101);
    check("no_done_after_reset", 4'(done_count), 4'd0);

`ifdef KEYPAD_EMU_BOUNCE_EN
    // 6. Bounce pattern on column 0 for key 0
    step(1'b1, 4'h0, 4'b1110);
    for (int i = 0; i < HOLD_C + GAP_C + 4; i++) step(1'b0, 4'h0, 4'b1110);
`endif

    // Random traffic; a refused code is held until it is accepted
    code_r = 4'($urandom);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        step(1'b1, code_r, rand_rows());
        if (last_accept) code_r = 4'($urandom);
      end else begin
        step(1'b0, code_r, rand_rows());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
